mips_mmio_bridge: RTL

- Parametrised memory-mapped I/O bridge between the MIPS data-memory port and the peripheral bus.
- Generalises the inline I/O decode to NUM_CH word-aligned channels at a configurable base, and adds a req/ack handshake with variable-latency peripherals.
- Stalls the processor while a peripheral access is outstanding, with a timeout guard.
- Sits between the ALUResult/WriteData paths and DataMemory/I/O in the MIPS top.

---
 rtl/mips_mmio_bridge_pkg.sv | 22 ++
 rtl/mips_mmio_bridge_if.sv | 32 +++
 rtl/mips_mmio_bridge_decode.sv | 27 ++
 rtl/mips_mmio_bridge.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mips_mmio_bridge_pkg.sv
// Shared types and constants for the MIPS memory-mapped I/O bridge.
package mips_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_IO_BASE    = 32'h0000_7FF0;
  localparam logic [63:0] TIMEOUT_READ_VALUE = '1;

  function automatic int ch_w(input int num_ch);
    return $clog2(num_ch);
  endfunction

  // A zero TIMEOUT still needs a one-bit counter to stay legal.
  function automatic int cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mips_mmio_bridge_if.sv
// Peripheral-side req/ack bus of the MMIO bridge.
interface mips_mmio_bridge_if #(
  parameter int DATA_W = 32,
  parameter int CH_W   = 2
);

  logic              IOReq;
  logic              IOWe;
  logic [CH_W-1:0]   IOAddr;
  logic [DATA_W-1:0] IOWriteData;
  logic              IOAck;
  logic [DATA_W-1:0] IOReadData;

  modport master (
    output IOReq,
    output IOWe,
    output IOAddr,
    output IOWriteData,
    input  IOAck,
    input  IOReadData
  );

  modport slave (
    input  IOReq,
    input  IOWe,
    input  IOAddr,
    input  IOWriteData,
    output IOAck,
    output IOReadData
  );

endinterface

// File: rtl/mips_mmio_bridge_decode.sv
// Address decode: I/O window hit, channel index, DataMemory write gate.
module mips_mmio_decode
  import mips_mmio_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter int                NUM_CH  = 4,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(DEFAULT_IO_BASE),
  parameter int                CH_W    = ch_w(NUM_CH)
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  output logic              is_io_o,
  output logic [CH_W-1:0]   ch_o,
  output logic              mem_we_o
);

  logic unused_addr;

  assign is_io_o  = (addr_i[ADDR_W-1:CH_W+2]
                     == IO_BASE[ADDR_W-1:CH_W+2]);
  assign ch_o     = addr_i[CH_W+1:2];
  assign mem_we_o = we_i & ~is_io_o;

  // Byte offset within a channel word has no meaning here.
  assign unused_addr = ^addr_i[1:0];

endmodule

// File: rtl/mips_mmio_bridge.sv
// MMIO bridge: decodes the I/O window, runs the req/ack handshake and
// stalls the CPU while a peripheral access is outstanding.
module mips_mmio_bridge
  import mips_mmio_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 32,
  parameter int                NUM_CH  = 4,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(DEFAULT_IO_BASE),
  parameter int                TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWriteData,
  input  logic              CpuWriteEn,
  input  logic              CpuReadEn,
  output logic [DATA_W-1:0] CpuReadData,
  output logic              CpuStall,
  input  logic [DATA_W-1:0] MemReadData,
  output logic              MemWriteEn,
  output logic              IsIO,
  output logic              TimeoutErr,
  mips_mmio_bridge_if.master io
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam int CW   = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  if (NUM_CH < 2 || NUM_CH > 16 ||
      (NUM_CH & (NUM_CH - 1)) != 0) begin : g_bad_num_ch
    $error("NUM_CH must be a power of 2 in 2..16");
  end

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              terr_q, terr_d;

  logic [CH_W-1:0]   ch;
  logic [CW-1:0]     cnt_nxt;
  logic              access;
  logic              timeout_hit;

  mips_mmio_decode #(
    .ADDR_W  (ADDR_W),
    .NUM_CH  (NUM_CH),
    .IO_BASE (IO_BASE),
    .CH_W    (CH_W)
  ) u_decode (
    .addr_i   (CpuAddr),
    .we_i     (CpuWriteEn),
    .is_io_o  (IsIO),
    .ch_o     (ch),
    .mem_we_o (MemWriteEn)
  );

  assign access      = IsIO & (CpuWriteEn | CpuReadEn);
  assign cnt_nxt     = cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT > 0) && (cnt_nxt == TO_LIM);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    ch_d    = ch_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = CpuWriteEn;
          ch_d    = ch;
          wdata_d = CpuWriteData;
          cnt_d   = '0;
        end
      end
      REQ: begin
        cnt_d = cnt_nxt;
        // Ack has priority over a timeout expiring on the same edge.
        if (io.IOAck) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) rdata_d = io.IOReadData;
        end else if (timeout_hit) begin
          state_d = DONE;
          req_d   = 1'b0;
          rdata_d = DATA_W'(TIMEOUT_READ_VALUE);
          terr_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      ch_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      ch_q    <= ch_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    CpuStall = 1'b0;
    if (RESET) begin
      unique case (state_q)
        IDLE:    CpuStall = access;
        REQ:     CpuStall = 1'b1;
        default: CpuStall = 1'b0;
      endcase
    end
  end

  assign CpuReadData    = IsIO ? rdata_q : MemReadData;
  assign TimeoutErr     = terr_q;
  assign io.IOReq       = req_q;
  assign io.IOWe        = we_q;
  assign io.IOAddr      = ch_q;
  assign io.IOWriteData = wdata_q;

endmodule
